// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-port main-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 128;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StServeI = 2'd1,
        StServeD = 2'd2
    } arb_state_e;

    typedef enum logic {
        OpRd = 1'b0,
        OpWr = 1'b1
    } arb_op_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter; slave is the arbiter view,
// master is the view of the caches plus main memory.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_readdata;
    logic              i_busywait;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_writedata;
    logic [DATA_W-1:0] d_readdata;
    logic              d_busywait;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_busywait;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_writedata,
        input  mem_readdata, mem_busywait,
        output i_readdata, i_busywait, d_readdata, d_busywait,
        output mem_read, mem_write, mem_addr, mem_writedata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_writedata,
        output mem_readdata, mem_busywait,
        input  i_readdata, i_busywait, d_readdata, d_busywait,
        input  mem_read, mem_write, mem_addr, mem_writedata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache (read) and D-cache (read/write) miss paths.
// Define ARB_RR_EN for round-robin priority; otherwise D always beats I.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    arb_op_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic i_req, d_req, d_win, done;

    always_comb begin
        i_req = bus.i_read;
        d_req = bus.d_read | bus.d_write;
        done  = (state_q != StIdle) & ~bus.mem_busywait;
    end

`ifdef ARB_RR_EN
    // 1: D side holds priority on a contested grant, 0: I side does.
    logic prio_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_d_q <= 1'b1;
        end else if (done) begin
            prio_d_q <= (state_q == StServeI);
        end
    end

    always_comb d_win = d_req & (prio_d_q | ~i_req);
`else
    always_comb d_win = d_req;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (d_win) begin
                    state_d = StServeD;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_writedata;
                    op_d    = bus.d_write ? OpWr : OpRd;
                end else if (i_req) begin
                    state_d = StServeI;
                    addr_d  = bus.i_addr;
                    op_d    = OpRd;
                end
            end
            StServeI, StServeD: begin
                if (!bus.mem_busywait) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= OpRd;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Strobes decode from registered state, so they are low in every idle gap.
    always_comb begin
        bus.mem_read      = (state_q != StIdle) & (op_q == OpRd);
        bus.mem_write     = (state_q != StIdle) & (op_q == OpWr);
        bus.mem_addr      = addr_q;
        bus.mem_writedata = wdata_q;
        bus.i_readdata    = bus.mem_readdata;
        bus.d_readdata    = bus.mem_readdata;
        bus.i_busywait    = i_req & ~((state_q == StServeI) & ~bus.mem_busywait);
        bus.d_busywait    = d_req & ~((state_q == StServeD) & ~bus.mem_busywait);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow ARB_RR_EN when set.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    localparam logic [DATA_W-1:0] RD1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [DATA_W-1:0] RD2 = 128'hA5A5_5A5A_0F0F_F0F0_1111_2222_3333_4444;
    localparam logic [DATA_W-1:0] WD1 = 128'hDEAD_BEEF_DEAD_BEEF_CAFE_F00D_1234_5678;
    localparam logic [DATA_W-1:0] WD2 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic grant_d;

    initial begin
        bus.i_read       = 1'b0;
        bus.i_addr       = '0;
        bus.d_read       = 1'b0;
        bus.d_write      = 1'b0;
        bus.d_addr       = '0;
        bus.d_writedata  = '0;
        bus.mem_readdata = '0;
        bus.mem_busywait = 1'b1;

        // Reset state
        next_cycle();
        next_cycle();
        #1;
        check("rst_mem_read", bus.mem_read, 1'b0);
        check("rst_mem_write", bus.mem_write, 1'b0);
        check("rst_mem_addr", bus.mem_addr, '0);
        check("rst_mem_wdata", bus.mem_writedata, '0);
        check("rst_i_busy", bus.i_busywait, 1'b0);
        check("rst_d_busy", bus.d_busywait, 1'b0);
        rst = 1'b0;

        // I read, memory busy for 3 cycles
        next_cycle();
        bus.i_read = 1'b1;
        bus.i_addr = 28'h0000010;
        #1;
        check("i3_c0_busy", bus.i_busywait, 1'b1);
        check("i3_c0_rd", bus.mem_read, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            #1;
            check("i3_busy_rd", bus.mem_read, 1'b1);
            check("i3_busy_addr", bus.mem_addr, 28'h0000010);
            check("i3_busy_ibw", bus.i_busywait, 1'b1);
        end
        next_cycle();
        bus.mem_busywait = 1'b0;
        bus.mem_readdata = RD1;
        #1;
        check("i3_c3_rd", bus.mem_read, 1'b1);
        check("i3_c3_ibw", bus.i_busywait, 1'b0);
        check("i3_c3_data", bus.i_readdata, RD1);
        next_cycle();
        bus.i_read = 1'b0;
        bus.mem_busywait = 1'b1;
        #1;
        check("i3_c4_rd", bus.mem_read, 1'b0);
        check("i3_c4_ibw", bus.i_busywait, 1'b0);

        // Simultaneous I read and D write: D first, I one cycle after D's idle
        next_cycle();
        bus.i_read = 1'b1;
        bus.i_addr = 28'h0000030;
        bus.d_write = 1'b1;
        bus.d_addr = 28'h00000A0;
        bus.d_writedata = WD1;
        #1;
        check("sim_c0_ibw", bus.i_busywait, 1'b1);
        check("sim_c0_dbw", bus.d_busywait, 1'b1);
        next_cycle();
        #1;
        check("sim_c1_wr", bus.mem_write, 1'b1);
        check("sim_c1_rd", bus.mem_read, 1'b0);
        check("sim_c1_addr", bus.mem_addr, 28'h00000A0);
        check("sim_c1_wdata", bus.mem_writedata, WD1);
        check("sim_c1_ibw", bus.i_busywait, 1'b1);
        check("sim_c1_dbw", bus.d_busywait, 1'b1);
        next_cycle();
        bus.mem_busywait = 1'b0;
        #1;
        check("sim_c2_dbw", bus.d_busywait, 1'b0);
        check("sim_c2_ibw", bus.i_busywait, 1'b1);
        check("sim_c2_wr", bus.mem_write, 1'b1);
        next_cycle();
        bus.d_write = 1'b0;
        bus.mem_busywait = 1'b1;
        #1;
        check("sim_c3_wr", bus.mem_write, 1'b0);
        check("sim_c3_rd", bus.mem_read, 1'b0);
        check("sim_c3_ibw", bus.i_busywait, 1'b1);
        next_cycle();
        bus.mem_busywait = 1'b0;
        bus.mem_readdata = RD2;
        #1;
        check("sim_c4_rd", bus.mem_read, 1'b1);
        check("sim_c4_addr", bus.mem_addr, 28'h0000030);
        check("sim_c4_ibw", bus.i_busywait, 1'b0);
        check("sim_c4_data", bus.i_readdata, RD2);
        next_cycle();
        bus.i_read = 1'b0;
        bus.mem_busywait = 1'b1;
        #1;
        check("sim_c5_rd", bus.mem_read, 1'b0);

        // D address changes mid-service; captured address must hold
        next_cycle();
        bus.d_read = 1'b1;
        bus.d_addr = 28'h0000020;
        #1;
        next_cycle();
        bus.d_addr = 28'h0000FFF;
        #1;
        check("cap_c1_addr", bus.mem_addr, 28'h0000020);
        check("cap_c1_rd", bus.mem_read, 1'b1);
        next_cycle();
        #1;
        check("cap_c2_addr", bus.mem_addr, 28'h0000020);
        next_cycle();
        bus.mem_busywait = 1'b0;
        bus.mem_readdata = RD1;
        #1;
        check("cap_c3_addr", bus.mem_addr, 28'h0000020);
        check("cap_c3_dbw", bus.d_busywait, 1'b0);
        check("cap_c3_data", bus.d_readdata, RD1);
        next_cycle();
        bus.d_read = 1'b0;
        bus.mem_busywait = 1'b1;
        #1;
        check("cap_c4_rd", bus.mem_read, 1'b0);
        check("cap_c4_addr", bus.mem_addr, 28'h0000020);

        // Reset during SERVE_I
        next_cycle();
        bus.i_read = 1'b1;
        bus.i_addr = 28'h0000044;
        #1;
        next_cycle();
        #1;
        check("rsti_c1_rd", bus.mem_read, 1'b1);
        rst = 1'b1;
        next_cycle();
        #1;
        check("rsti_c2_rd", bus.mem_read, 1'b0);
        check("rsti_c2_addr", bus.mem_addr, '0);
        check("rsti_c2_ibw", bus.i_busywait, 1'b1);
        check("rsti_c2_dbw", bus.d_busywait, 1'b0);
        rst = 1'b0;
        bus.i_read = 1'b0;
        #1;
        check("rsti_c2_ibw_drop", bus.i_busywait, 1'b0);
        next_cycle();
        #1;
        check("rsti_c3_rd", bus.mem_read, 1'b0);

        // Both sides requesting continuously with zero-wait memory
        next_cycle();
        bus.i_read = 1'b1;
        bus.i_addr = 28'h0000040;
        bus.d_read = 1'b1;
        bus.d_addr = 28'h0000050;
        bus.mem_busywait = 1'b0;
        #1;
        check("pri_c0_rd", bus.mem_read, 1'b0);
        check("pri_c0_ibw", bus.i_busywait, 1'b1);
        check("pri_c0_dbw", bus.d_busywait, 1'b1);
        for (int n = 0; n < 4; n++) begin
`ifdef ARB_RR_EN
            grant_d = (n % 2 == 0);
`else
            grant_d = 1'b1;
`endif
            next_cycle();
            #1;
            check("pri_serve_rd", bus.mem_read, 1'b1);
            check("pri_serve_addr", bus.mem_addr, grant_d ? 28'h0000050 : 28'h0000040);
            check("pri_serve_dbw", bus.d_busywait, !grant_d);
            check("pri_serve_ibw", bus.i_busywait, grant_d);
            next_cycle();
            #1;
            check("pri_gap_rd", bus.mem_read, 1'b0);
        end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        next_cycle();
        #1;
        check("pri_end_rd", bus.mem_read, 1'b0);

        // Both D strobes high: write wins, zero-wait single-cycle strobe
        next_cycle();
        bus.d_read = 1'b1;
        bus.d_write = 1'b1;
        bus.d_addr = 28'h0000060;
        bus.d_writedata = WD2;
        #1;
        next_cycle();
        #1;
        check("rw_wr", bus.mem_write, 1'b1);
        check("rw_rd", bus.mem_read, 1'b0);
        check("rw_wdata", bus.mem_writedata, WD2);
        check("rw_dbw", bus.d_busywait, 1'b0);
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
        next_cycle();
        #1;
        check("rw_gap_wr", bus.mem_write, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one main-memory port between the instruction-cache miss path (read-only) and the data-cache miss/write-back path (read/write). It sits between the caches and main memory, outside the pipeline. The pipeline's BUSYWAIT_IN is driven by the caches, which are in turn stalled by this block. Each accepted request is captured into registers, so memory sees stable address and data for the whole transaction.

## Interface
- ADDR_W, 28, block-address width (byte address >> 4)
- DATA_W, 128, block data width
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- I_READ  in  1  I-side read request; held until I_BUSYWAIT low
- I_ADDR  in  ADDR_W  I-side block address
- I_READDATA  out  DATA_W  read data to I-side; valid when I_BUSYWAIT=0 with I_READ=1
- I_BUSYWAIT  out  1  I-side stall
- D_READ  in  1  D-side read request
- D_WRITE  in  1  D-side write request
- D_ADDR  in  ADDR_W  D-side block address
- D_WRITEDATA  in  DATA_W  D-side write block
- D_READDATA  out  DATA_W  read data to D-side
- D_BUSYWAIT  out  1  D-side stall
- MEM_READ  out  1  memory read strobe
- MEM_WRITE  out  1  memory write strobe
- MEM_ADDR  out  ADDR_W  captured address
- MEM_WRITEDATA  out  DATA_W  captured write data
- MEM_READDATA  in  DATA_W  memory read data
- MEM_BUSYWAIT  in  1  high while memory is busy; low in the cycle data is valid or the write is done

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE to SERVE_D:
  - Taken at the edge when D_READ|D_WRITE and D has priority, or I_READ is low.
  - Captures D_ADDR and D_WRITEDATA.
  - Captures op: write if D_WRITE, else read. D_WRITE wins if both D strobes are high.
- IDLE to SERVE_I: taken at the edge when I_READ and no D grant; captures I_ADDR.
- SERVE_x to IDLE: taken at the edge ending any cycle with MEM_BUSYWAIT=0.
- MEM_READ/MEM_WRITE are asserted only in SERVE states, decoded from the captured op. They are 0 in IDLE.
- MEM_ADDR and MEM_WRITEDATA always drive the capture registers.
- I_READDATA and D_READDATA are both wired directly to MEM_READDATA.
- I_BUSYWAIT = I_READ & ~(state==SERVE_I & ~MEM_BUSYWAIT). This is combinational.
- D_BUSYWAIT = (D_READ|D_WRITE) & ~(state==SERVE_D & ~MEM_BUSYWAIT).
- Default priority is fixed, D over I.
- If a request is dropped mid-service, the transaction still completes from the captured registers, and no busywait is returned to anyone.
- Reset values: state=IDLE, MEM_READ=0, MEM_WRITE=0, capture registers=0, priority pointer=D.
- RST mid-transaction: IDLE on the next edge and strobes drop. The memory transaction is abandoned; memory must tolerate a strobe drop.

## Timing
- Request raised in cycle 0 while IDLE: SERVE in cycle 1, MEM strobe high in cycle 1.
- Memory completes in cycle k (MEM_BUSYWAIT=0): requester busywait is 0 in cycle k and data is valid in cycle k.
- IDLE in cycle k+1, strobes low. This guarantees memory sees at least one strobe-low cycle between transactions.
- Requester must drop its request at the edge ending cycle k.
- Back-to-back I after D: I grant is sampled at the end of k+1, I strobe rises in k+2.
- Zero-wait memory (MEM_BUSYWAIT=0 in the first SERVE cycle): completes in cycle 1. Minimum occupancy is 2 cycles per transaction.
- Simultaneous I and D in IDLE: a single grant only; the loser stays stalled with busywait high.

## Configuration
- ARB_RR_EN defined:
  - Round-robin priority.
  - A 1-bit priority pointer flips to the non-granted side after every completed transaction; a contested IDLE grants the pointer side.
  - An uncontested request is granted regardless of the pointer.
- ARB_RR_EN undefined: fixed D-over-I priority; the pointer register is not built.

## Structure
- Shared package mem_arb_pkg: state encodings (IDLE=2'd0, SERVE_I=2'd1, SERVE_D=2'd2), op encodings (OP_RD, OP_WR), ADDR_W/DATA_W defaults.
- Single module; no sub-module is warranted. The FSM, capture registers and grant logic are tightly coupled.

## Test plan
- I_READ, I_ADDR=0x0000010, memory 3-cycle busy:
  - MEM_READ=1 in cycles 1–3 with MEM_ADDR=0x0000010.
  - I_BUSYWAIT=0 in cycle 3 with I_READDATA=MEM_READDATA.
  - MEM_READ=0 in cycle 4.
- I_READ and D_WRITE raised in the same cycle, D_ADDR=0x00000A0, D_WRITEDATA=0xDEADBEEF…:
  - D is served first; MEM_WRITE=1 with the captured data.
  - I_BUSYWAIT stays 1 throughout; I is granted 1 cycle after D's completion idle.
- D_ADDR changed from 0x0000020 to 0x0000FFF during SERVE_D: MEM_ADDR stays 0x0000020 until completion.
- RST asserted during SERVE_I: IDLE and MEM_READ=0 on the next edge; all busywaits follow request inputs only.
- ARB_RR_EN, I and D both requesting continuously: grant sequence is D, I, D, I. Without ARB_RR_EN: D, D, D while D is held.
- Zero-wait memory: MEM_READ high for exactly 1 cycle; the next strobe is no earlier than 2 cycles later.
